// File: rtl/demux_router.sv
// Registered 1-to-N stream demultiplexer: each accepted beat lands in exactly one
// per-channel holding register; beats with an out-of-range select are dropped and counted.
module demux_router #(
    parameter int N_OUT = 3,
    parameter int SEL_W = 2,
    parameter int DW    = 8,
    parameter int ERR_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [SEL_W-1:0]     in_sel,
    input  logic [DW-1:0]        in_data,
    output logic [N_OUT-1:0]     out_valid,
    input  logic [N_OUT-1:0]     out_ready,
    output logic [N_OUT*DW-1:0]  out_data,
    output logic                 err_pulse,
    output logic [ERR_W-1:0]     err_cnt
);

    localparam logic [SEL_W:0]   NumOut = (SEL_W+1)'(N_OUT);
    localparam logic [ERR_W-1:0] ErrMax = {ERR_W{1'b1}};

    logic [N_OUT-1:0]          chanValid_q, chanValid_d;
    logic [N_OUT-1:0][DW-1:0]  chanData_q,  chanData_d;
    logic                      errPulse_q,  errPulse_d;
    logic [ERR_W-1:0]          errCnt_q,    errCnt_d;

    logic [N_OUT-1:0] selHit;
    logic [N_OUT-1:0] chanFree;
    logic [N_OUT-1:0] load;
    logic             selLegal;
    logic             accept;

    // One-hot decode of the legal codes; anything at or above N_OUT is the illegal range.
    always_comb begin
        selLegal = ({1'b0, in_sel} < NumOut);
        for (int k = 0; k < N_OUT; k++) begin
            selHit[k]   = (in_sel == SEL_W'(k));
            chanFree[k] = !chanValid_q[k] || out_ready[k];
        end
    end

    assign in_ready = selLegal ? |(selHit & chanFree) : 1'b1;
    assign accept   = in_valid && in_ready;
    assign load     = accept ? selHit : '0;

    // A loaded channel stays full even if it drained on the same edge.
    always_comb begin
        chanValid_d = chanValid_q;
        chanData_d  = chanData_q;
        for (int k = 0; k < N_OUT; k++) begin
            if (load[k]) begin
                chanValid_d[k] = 1'b1;
                chanData_d[k]  = in_data;
            end else if (out_ready[k]) begin
                chanValid_d[k] = 1'b0;
            end
        end
    end

    always_comb begin
        errPulse_d = accept && !selLegal;
        errCnt_d   = errCnt_q;
        if (errPulse_d && errCnt_q != ErrMax) begin
            errCnt_d = errCnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            chanValid_q <= '0;
            chanData_q  <= '0;
            errPulse_q  <= 1'b0;
            errCnt_q    <= '0;
        end else begin
            chanValid_q <= chanValid_d;
            chanData_q  <= chanData_d;
            errPulse_q  <= errPulse_d;
            errCnt_q    <= errCnt_d;
        end
    end

    assign out_valid = chanValid_q;
    assign out_data  = chanData_q;
    assign err_pulse = errPulse_q;
    assign err_cnt   = errCnt_q;

endmodule

// File: doc/demux_router.md
# demux_router

Registered 1-to-N stream demultiplexer: the receive-side counterpart of the `sel`-driven 3-input mux. One valid/ready input stream carries a select tag and a payload. Each accepted beat is routed to exactly one of N registered output channels. Select codes with no output channel are consumed, dropped and counted, so no `x` ever reaches a channel. It sits between a shared bus and per-destination consumers.

## Interface
- `N_OUT`, 3, number of output channels; 1..2**SEL_W
- `SEL_W`, 2, select tag width
- `DW`, 8, payload width
- `ERR_W`, 8, error counter width
- `clk` input 1: single clock, all state on rising edge
- `rst` input 1: synchronous, active-high reset
- `in_valid` input 1: input beat present
- `in_ready` output 1: input beat accepted this cycle when high with `in_valid`
- `in_sel` input SEL_W: destination channel index
- `in_data` input DW: payload
- `out_valid` output N_OUT: per-channel holding register full
- `out_ready` input N_OUT: per-channel consumer accepts
- `out_data` output N_OUT*DW: channel k occupies bits [k*DW +: DW]
- `err_pulse` output 1: registered one-cycle pulse for each dropped illegal beat
- `err_cnt` output ERR_W: saturating count of dropped beats

## Operation
- Legal select: `in_sel` < N_OUT. Illegal select: `in_sel` >= N_OUT. With defaults, only 2'b11 is illegal.
- `in_ready` is combinational from `in_sel`, `out_valid` and `out_ready`:
  - legal: `!out_valid[in_sel] || out_ready[in_sel]`
  - illegal: 1, because illegal beats are always consumed
- Accept means `in_valid && in_ready`.
- Legal accept: `out_data[in_sel]` <= `in_data` and `out_valid[in_sel]` <= 1 on the next edge. No other channel changes.
- Illegal accept: no channel changes. `err_pulse` <= 1 on the next edge, else 0. `err_cnt` increments and holds at 2**ERR_W-1.
- Channel drain: when `out_valid[k] && out_ready[k]` and channel k receives no new beat on the same edge, `out_valid[k]` <= 0.
- Drain and refill on the same edge: `out_valid[k]` stays 1 and `out_data[k]` takes the new payload. A full channel therefore sustains one beat per cycle.
- Ordering: beats for the same channel leave in acceptance order. Different channels are independent.
- A stalled channel blocks the input only while `in_sel` addresses it (head-of-line). Other channels keep draining.
- Stability:
  - `out_data[k]` holds while `out_valid[k]` && !`out_ready[k]`.
  - `out_data[k]` is don't-care while `out_valid[k]` = 0, but must not be `x` after reset.
- Selection decode is parallel: each legal code matches exactly one channel, and the illegal range is fully covered.

## Timing
- Reset (synchronous, dominates all other activity):
  - `out_valid` = 0, `out_data` = 0, `err_pulse` = 0, `err_cnt` = 0.
  - `in_ready` follows its formula with `out_valid` = 0, so it reads 1.
  - No accept is recorded on a reset edge.
- Reset mid-operation: all held beats are discarded and the counter clears. The beat presented on the reset edge is lost.
- Latency: accept at edge t; `out_valid[k]` and `out_data[k]` are visible after edge t, for consumption at edge t+1.
- `err_pulse` is high during the cycle after the illegal accept edge.
- Combinational paths:
  - `in_sel` -> `in_ready`
  - `out_ready` -> `in_ready`
  - No path from `in_valid` to any output.
- Counter saturation: at max value, further illegal beats still pulse `err_pulse` but leave `err_cnt` unchanged.

## Test plan
- Route each channel: after reset, send sel=0/1/2 with data 0xA0/0xB1/0xC2, `out_ready` = 3'b111.
  - Each `out_valid[k]` is high exactly one cycle after its accept.
  - Data matches per channel; no cross-channel writes.
- Illegal select: send sel=3, data 0x55, with `out_valid` = 0.
  - `in_ready` = 1; no `out_valid` rises.
  - `err_pulse` is high for one cycle; `err_cnt` = 1.
  - Send 300 illegal beats back-to-back: `err_cnt` = 255 and holds; `err_pulse` stays high every cycle.
- Backpressure: `out_ready[1]` = 0; send two beats to sel=1 (0x11, 0x22).
  - The first is held and `in_ready` drops for the second.
  - A sel=0 beat is accepted meanwhile.
  - Raising `out_ready[1]` delivers 0x11 then 0x22 in order.
- Full-rate refill: sel=2 every cycle for 8 beats with `out_ready[2]` = 1.
  - `in_ready` is 1 throughout; `out_valid[2]` stays high.
  - The data sequence is identical, delayed one cycle.
- Reset mid-operation: `rst` = 1 for one cycle while channels 0 and 2 hold data and `err_cnt` = 5.
  - All `out_valid` = 0, `out_data` = 0, `err_cnt` = 0 next cycle.
  - The beat presented on the reset edge never appears.
